// File: rtl/dcw_lane_serializer.sv
// DCW lane serializer: double-buffers NLANE-wide control-word frames and issues one lane per
// FOD_CLK cycle, while packing decoded multiphase-sampler phase errors into PHE_XN.
module dcw_lane_serializer #(
    parameter int NLANE      = 4,
    parameter int MMD_W      = 6,
    parameter int DTC_W      = 10,
    parameter int MP_SEG_BIN = 3,
    parameter int MMD_DEF    = 4
) (
    input  logic                        FOD_CLK,
    input  logic                        ARST,
    input  logic                        DCW_VLD,
    output logic                        DCW_RDY,
    input  logic [NLANE*MMD_W-1:0]      MMD_DCW_XN,
    input  logic [NLANE*DTC_W-1:0]      DTC_DCW_XN,
    input  logic [NLANE-1:0]            RT_DCW_XN,
    output logic [MMD_W-1:0]            MMD_DCW,
    output logic [DTC_W-1:0]            DTC_DCW,
    output logic                        RT_DCW,
    output logic                        FRAME,
    output logic                        UNDERFLOW,
    input  logic                        ERR_CLR,
    input  logic [(2**MP_SEG_BIN)-1:0]  PSAMP,
    output logic [NLANE*MP_SEG_BIN-1:0] PHE_XN,
    output logic                        PHE_VLD,
    output logic                        DBG_STATE
);

    localparam int MP_SEG = 2 ** MP_SEG_BIN;
    localparam int CNT_W  = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NLANE - 1);
    localparam logic [MMD_W-1:0] MMD_RST   = MMD_W'(MMD_DEF);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Lane sequencer state
    logic [0:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [NLANE*MMD_W-1:0]   r_act_mmd;
    logic [NLANE*DTC_W-1:0]   r_act_dtc;
    logic [NLANE-1:0]         r_act_rt;
    logic [NLANE*MMD_W-1:0]   r_sh_mmd;
    logic [NLANE*DTC_W-1:0]   r_sh_dtc;
    logic [NLANE-1:0]         r_sh_rt;
    logic                     r_sh_full;

    logic [MMD_W-1:0]         r_mmd;
    logic [DTC_W-1:0]         r_dtc;
    logic                     r_rt;
    logic                     r_frame;
    logic                     r_underflow;

    // Phase packing state
    logic [MP_SEG_BIN-1:0]       r_phe_last;
    logic [CNT_W-1:0]            r_slot;
    logic [NLANE*MP_SEG_BIN-1:0] r_stage;
    logic                        r_phe_load;
    logic [NLANE*MP_SEG_BIN-1:0] r_phe_xn;
    logic                        r_phe_vld;

    logic                     w_accept;
    logic                     w_wrap;
    logic                     w_bypass;
    logic                     w_reload;
    logic                     w_underflow;
    logic [MMD_W-1:0]         w_lane_mmd;
    logic [DTC_W-1:0]         w_lane_dtc;
    logic                     w_lane_rt;
    logic [MP_SEG_BIN-1:0]    w_phe;

    // Handshake: a frame transfers on any rising edge where DCW_VLD and DCW_RDY are both high;
    // DCW_RDY depends only on the registered shadow-full flag, never on DCW_VLD.
    assign DCW_RDY  = ~r_sh_full;
    assign w_accept = DCW_VLD & ~r_sh_full;

    assign w_wrap      = (r_state == S_RUN) && (r_cnt == LAST_LANE);
    assign w_reload    = w_wrap && r_sh_full;
    // A frame goes straight to the active register when idle or when it lands exactly on an empty wrap.
    assign w_bypass    = w_accept && ((r_state == S_IDLE) || (w_wrap && !r_sh_full));
    assign w_underflow = w_wrap && !r_sh_full && !w_accept;

    always_comb begin
        w_lane_mmd = r_act_mmd[r_cnt*MMD_W +: MMD_W];
        w_lane_dtc = r_act_dtc[r_cnt*DTC_W +: DTC_W];
        w_lane_rt  = r_act_rt[r_cnt];
    end

    always_ff @(posedge FOD_CLK or posedge ARST) begin
        if (ARST) begin
            r_sh_mmd  <= '0;
            r_sh_dtc  <= '0;
            r_sh_rt   <= '0;
            r_sh_full <= 1'b0;
        end else if (w_reload) begin
            r_sh_full <= 1'b0;
        end else if (w_accept && !w_bypass) begin
            r_sh_mmd  <= MMD_DCW_XN;
            r_sh_dtc  <= DTC_DCW_XN;
            r_sh_rt   <= RT_DCW_XN;
            r_sh_full <= 1'b1;
        end
    end

    always_ff @(posedge FOD_CLK or posedge ARST) begin
        if (ARST) begin
            r_act_mmd <= '0;
            r_act_dtc <= '0;
            r_act_rt  <= '0;
        end else if (w_bypass) begin
            r_act_mmd <= MMD_DCW_XN;
            r_act_dtc <= DTC_DCW_XN;
            r_act_rt  <= RT_DCW_XN;
        end else if (w_reload) begin
            r_act_mmd <= r_sh_mmd;
            r_act_dtc <= r_sh_dtc;
            r_act_rt  <= r_sh_rt;
        end
    end

    always_ff @(posedge FOD_CLK or posedge ARST) begin
        if (ARST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (w_underflow) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge FOD_CLK or posedge ARST) begin
        if (ARST) begin
            r_mmd   <= MMD_RST;
            r_dtc   <= '0;
            r_rt    <= 1'b0;
            r_frame <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_mmd   <= w_lane_mmd;
            r_dtc   <= w_lane_dtc;
            r_rt    <= w_lane_rt;
            r_frame <= (r_cnt == '0);
        end else begin
            r_mmd   <= MMD_RST;
            r_dtc   <= '0;
            r_rt    <= 1'b0;
            r_frame <= 1'b0;
        end
    end

    // A new underflow outranks a coincident clear.
    always_ff @(posedge FOD_CLK or posedge ARST) begin
        if (ARST) begin
            r_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_underflow <= 1'b1;
        end else if (ERR_CLR) begin
            r_underflow <= 1'b0;
        end
    end

    // Highest falling edge of the circular thermometer; a flat sample keeps the previous phase.
    always_comb begin
        w_phe = r_phe_last;
        for (int i = 0; i < MP_SEG; i++) begin
            if (PSAMP[i] && !PSAMP[(i + 1) % MP_SEG]) begin
                w_phe = MP_SEG_BIN'(i);
            end
        end
    end

    always_ff @(posedge FOD_CLK or posedge ARST) begin
        if (ARST) begin
            r_phe_last <= '0;
            r_slot     <= '0;
            r_stage    <= '0;
            r_phe_load <= 1'b0;
            r_phe_xn   <= '0;
            r_phe_vld  <= 1'b0;
        end else begin
            r_phe_last <= w_phe;
            r_stage[r_slot*MP_SEG_BIN +: MP_SEG_BIN] <= w_phe;
            r_slot     <= (r_slot == LAST_LANE) ? '0 : r_slot + 1'b1;
            r_phe_load <= (r_slot == LAST_LANE);
            r_phe_vld  <= r_phe_load;
            if (r_phe_load) begin
                r_phe_xn <= r_stage;
            end
        end
    end

    assign MMD_DCW   = r_mmd;
    assign DTC_DCW   = r_dtc;
    assign RT_DCW    = r_rt;
    assign FRAME     = r_frame;
    assign UNDERFLOW = r_underflow;
    assign PHE_XN    = r_phe_xn;
    assign PHE_VLD   = r_phe_vld;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_dcw_lane_serializer.sv
// Directed bench for dcw_lane_serializer: lane sequencing, shadow/bypass handshake,
// underflow flag handling, asynchronous reset and phase-error packing.
module tb_dcw_lane_serializer;

    logic        fod_clk = 1'b0;
    logic        arst;
    logic        dcw_vld;
    logic        dcw_rdy;
    logic [23:0] mmd_xn;
    logic [39:0] dtc_xn;
    logic [3:0]  rt_xn;
    logic [5:0]  mmd_dcw;
    logic [9:0]  dtc_dcw;
    logic        rt_dcw;
    logic        frame;
    logic        underflow;
    logic        err_clr;
    logic [7:0]  psamp;
    logic [11:0] phe_xn;
    logic        phe_vld;
    logic        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    dcw_lane_serializer #(
        .NLANE(4), .MMD_W(6), .DTC_W(10), .MP_SEG_BIN(3), .MMD_DEF(4)
    ) dut (
        .FOD_CLK    (fod_clk),
        .ARST       (arst),
        .DCW_VLD    (dcw_vld),
        .DCW_RDY    (dcw_rdy),
        .MMD_DCW_XN (mmd_xn),
        .DTC_DCW_XN (dtc_xn),
        .RT_DCW_XN  (rt_xn),
        .MMD_DCW    (mmd_dcw),
        .DTC_DCW    (dtc_dcw),
        .RT_DCW     (rt_dcw),
        .FRAME      (frame),
        .UNDERFLOW  (underflow),
        .ERR_CLR    (err_clr),
        .PSAMP      (psamp),
        .PHE_XN     (phe_xn),
        .PHE_VLD    (phe_vld),
        .DBG_STATE  (dbg_state)
    );

    always #5 fod_clk = ~fod_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Lane contents of frame f, lane k
    function automatic int exp_mmd(input int f, input int k);
        return 4 + k + 8 * f;
    endfunction
    function automatic int exp_dtc(input int f, input int k);
        return f * 100 + (k + 1) * 10;
    endfunction
    function automatic int exp_rt(input int f, input int k);
        return (k + f) & 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_frame(input int f);
        for (int k = 0; k < 4; k++) begin
            mmd_xn[k*6 +: 6]  = 6'(exp_mmd(f, k));
            dtc_xn[k*10 +: 10] = 10'(exp_dtc(f, k));
            rt_xn[k]          = 1'(exp_rt(f, k));
        end
    endtask

    task automatic do_reset();
        @(negedge fod_clk);
        arst = 1'b1;
        @(negedge fod_clk);
        arst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_mmd"}, 32'(mmd_dcw), 32'd4);
        chk({tag, "_dtc"}, 32'(dtc_dcw), 32'd0);
        chk({tag, "_rt"}, 32'(rt_dcw), 32'd0);
        chk({tag, "_frame"}, 32'(frame), 32'd0);
    endtask

    task automatic chk_lane(input string tag, input int f, input int k);
        chk({tag, "_mmd"}, 32'(mmd_dcw), 32'(exp_mmd(f, k)));
        chk({tag, "_dtc"}, 32'(dtc_dcw), 32'(exp_dtc(f, k)));
        chk({tag, "_rt"}, 32'(rt_dcw), 32'(exp_rt(f, k)));
        chk({tag, "_frame"}, 32'(frame), 32'(k == 0));
    endtask

    initial begin
        arst    = 1'b1;
        dcw_vld = 1'b0;
        err_clr = 1'b0;
        mmd_xn  = '0;
        dtc_xn  = '0;
        rt_xn   = '0;
        psamp   = 8'b0000_0111;

        // Reset state
        repeat (2) @(negedge fod_clk);
        chk_idle("rst");
        chk("rst_rdy", 32'(dcw_rdy), 32'd1);
        chk("rst_uf", 32'(underflow), 32'd0);
        chk("rst_phe", 32'(phe_xn), 32'd0);
        chk("rst_phe_vld", 32'(phe_vld), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        arst = 1'b0;

        // Single frame, accepted from IDLE
        set_frame(0);
        dcw_vld = 1'b1;
        @(negedge fod_clk);
        dcw_vld = 1'b0;
        chk_idle("t2_lat");
        chk("t2_state_run", 32'(dbg_state), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge fod_clk);
            chk_lane($sformatf("t2_l%0d", k), 0, k);
            chk($sformatf("t2_uf%0d", k), 32'(underflow), 32'(k == 3));
        end
        @(negedge fod_clk);
        chk_idle("t2_after");
        chk("t2_uf_sticky", 32'(underflow), 32'd1);
        chk("t2_state_idle", 32'(dbg_state), 32'd0);

        // ERR_CLR alone, then coincident with a new underflow
        err_clr = 1'b1;
        @(negedge fod_clk);
        err_clr = 1'b0;
        chk("t6_clr", 32'(underflow), 32'd0);
        set_frame(1);
        dcw_vld = 1'b1;
        @(negedge fod_clk);
        dcw_vld = 1'b0;
        repeat (3) @(negedge fod_clk);
        err_clr = 1'b1;
        @(negedge fod_clk);
        err_clr = 1'b0;
        chk_lane("t6_l3", 1, 3);
        chk("t6_set_wins", 32'(underflow), 32'd1);
        @(negedge fod_clk);
        chk("t6_sticky", 32'(underflow), 32'd1);

        // Bypass: next frame offered exactly on the wrap with the shadow empty
        do_reset();
        set_frame(2);
        dcw_vld = 1'b1;
        @(negedge fod_clk);
        dcw_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge fod_clk);
            chk_lane($sformatf("t4_a%0d", k), 2, k);
            if (k == 2) begin
                set_frame(3);
                dcw_vld = 1'b1;
            end
        end
        dcw_vld = 1'b0;
        chk("t4_rdy_no_shadow", 32'(dcw_rdy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge fod_clk);
            chk_lane($sformatf("t4_b%0d", k), 3, k);
            chk($sformatf("t4_uf%0d", k), 32'(underflow), 32'(k == 3));
        end
        @(negedge fod_clk);
        chk_idle("t4_after");

        // Streaming three frames with DCW_VLD held high
        do_reset();
        for (int i = 0; i < 12; i++) exp_q.push_back(10'(exp_dtc(1 + i / 4, i % 4)));
        set_frame(1);
        dcw_vld = 1'b1;
        @(negedge fod_clk);
        set_frame(2);
        for (int i = 0; i < 12; i++) begin
            @(negedge fod_clk);
            chk($sformatf("t3_dtc%0d", i), 32'(dtc_dcw), 32'(exp_q.pop_front()));
            chk_lane($sformatf("t3_l%0d", i), 1 + i / 4, i % 4);
            chk($sformatf("t3_rdy%0d", i), 32'(dcw_rdy), 32'(!((i < 3) || (i >= 4 && i < 7))));
            chk($sformatf("t3_uf%0d", i), 32'(underflow), 32'(i == 11));
            if (i == 0) set_frame(3);
            if (i == 4) dcw_vld = 1'b0;
        end
        @(negedge fod_clk);
        chk_idle("t3_after");
        chk("t3_uf_end", 32'(underflow), 32'd1);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a stream with a full shadow
        set_frame(4);
        dcw_vld = 1'b1;
        @(negedge fod_clk);
        set_frame(0);
        @(negedge fod_clk);
        chk_lane("t1_l0", 4, 0);
        @(negedge fod_clk);
        chk_lane("t1_l1", 4, 1);
        chk("t1_rdy_pre", 32'(dcw_rdy), 32'd0);
        chk("t1_phe_pre", 32'(phe_xn), 32'h492);
        arst    = 1'b1;
        dcw_vld = 1'b0;
        #1;
        chk_idle("t1_async");
        chk("t1_rdy", 32'(dcw_rdy), 32'd1);
        chk("t1_phe", 32'(phe_xn), 32'd0);
        chk("t1_uf", 32'(underflow), 32'd0);
        chk("t1_state", 32'(dbg_state), 32'd0);
        @(negedge fod_clk);
        arst = 1'b0;
        @(negedge fod_clk);
        chk_idle("t1_post");
        chk("t1_post_rdy", 32'(dcw_rdy), 32'd1);

        // Phase decode and packing
        do_reset();
        psamp = 8'b0000_1111;
        @(negedge fod_clk);
        chk("t5_vld0", 32'(phe_vld), 32'd0);
        psamp = 8'b1111_0000;
        @(negedge fod_clk);
        psamp = 8'hFF;
        @(negedge fod_clk);
        psamp = 8'b0011_1100;
        @(negedge fod_clk);
        psamp = 8'h00;
        chk("t5_phe_pre", 32'(phe_xn), 32'd0);
        chk("t5_vld_pre", 32'(phe_vld), 32'd0);
        @(negedge fod_clk);
        chk("t5_phe_g1", 32'(phe_xn), 32'hBFB);
        chk("t5_vld_g1", 32'(phe_vld), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge fod_clk);
            chk($sformatf("t5_vld_gap%0d", i), 32'(phe_vld), 32'd0);
            chk($sformatf("t5_phe_hold%0d", i), 32'(phe_xn), 32'hBFB);
        end
        @(negedge fod_clk);
        chk("t5_phe_g2", 32'(phe_xn), 32'hB6D);
        chk("t5_vld_g2", 32'(phe_vld), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
